// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
// Holds the controller state encoding and the iteration-counter sizing helper.
// No ports; imported by seq_restoring_divider and div_datapath.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DEF_WIDTH = 8;
  // Counter width for the default operand width; instances of other widths
  // size their counter through cnt_width().
  localparam int CNT_W = $clog2(DEF_WIDTH);

  // The counter runs WIDTH-1 down to 0, so $clog2(WIDTH) bits always suffice.
  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/div_datapath.sv
// Restoring-division datapath: A/Q/M registers, trial subtractor, sign fix-up, result registers.
// Ports: clk, rst (async, active-high); load/zero_load/shift/fix strobes from the controller;
//   sgn, dividend, divisor (operands, used on load/zero_load); quotient, remainder (held results).
module div_datapath
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             zero_load,
  input  logic             shift,
  input  logic             fix,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  // A carries one extra bit so the shifted partial remainder never wraps.
  logic [WIDTH:0]   a;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             neg_q;
  logic             neg_r;

  logic [WIDTH-1:0] dividend_mag;
  logic [WIDTH-1:0] divisor_mag;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH:0]   diff;

  always_comb begin
    // The MIN value negates to itself, which read as unsigned is exactly 2^(WIDTH-1).
    dividend_mag = (sgn && dividend[WIDTH-1]) ? -dividend : dividend;
    divisor_mag  = (sgn && divisor[WIDTH-1])  ? -divisor  : divisor;
    a_sh         = {a[WIDTH-1:0], q[WIDTH-1]};
    diff         = a_sh - {1'b0, m};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a         <= '0;
      q         <= '0;
      m         <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (load) begin
        a     <= '0;
        q     <= dividend_mag;
        m     <= divisor_mag;
        neg_q <= sgn & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r <= sgn & dividend[WIDTH-1];
      end else if (shift) begin
        // diff MSB clear means the trial subtraction did not go negative.
        if (!diff[WIDTH]) begin
          a <= diff;
          q <= {q[WIDTH-2:0], 1'b1};
        end else begin
          a <= a_sh;
          q <= {q[WIDTH-2:0], 1'b0};
        end
      end

      if (zero_load) begin
        quotient  <= '1;
        remainder <= dividend;
      end else if (fix) begin
        quotient  <= neg_q ? -q : q;
        remainder <= neg_r ? -a[WIDTH-1:0] : a[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider, one quotient bit per clock, with signed mode and zero/overflow flags.
// Ports: clk, rst (async, active-high); start, signed_mode, dividend, divisor (sampled when idle/done);
//   busy, done, quotient, remainder, div_by_zero, overflow.
module seq_restoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int             CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;

  logic sgn;
  logic zero_div;
  logic accept;
  logic load;
  logic zero_load;
  logic shift;
  logic fix;

  always_comb begin
    sgn       = SIGNED_EN && signed_mode;
    zero_div  = (divisor == '0);
    accept    = start && ((state == IDLE) || (state == DONE));
    load      = accept && !zero_div;
    zero_load = accept && zero_div;
    shift     = (state == CALC);
    fix       = (state == FIX);
    busy      = shift || fix;
    done      = (state == DONE);

    state_nx = state;
    count_nx = count;
    unique case (state)
      CALC: begin
        count_nx = count - 1'b1;
        if (count == '0) state_nx = FIX;
      end
      FIX:  state_nx = DONE;
      default: begin
        // IDLE and DONE both accept a new operation; DONE otherwise falls back to IDLE.
        state_nx = IDLE;
        if (accept) begin
          state_nx = zero_div ? DONE : CALC;
          count_nx = CNT_INIT;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end

  // Flags describe the operation most recently accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      div_by_zero <= zero_div;
      overflow    <= sgn && (dividend == MIN_VAL) && (&divisor);
    end
  end

  div_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .zero_load (zero_load),
    .shift     (shift),
    .fix       (fix),
    .sgn       (sgn),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: 8-bit and 16-bit instances against an arithmetic reference model.
module tb_seq_restoring_divider;

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    logic        ov;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          jm = 0;   // 0: start low while busy, 1: random junk starts, 2: start held high

  logic [1:0]  st;
  logic [1:0]  sm;
  logic [15:0] dd [2];
  logic [15:0] dv [2];
  wire  [1:0]  bsy, dn, dz, ov;
  wire  [7:0]  q8, r8;
  wire  [15:0] q16, r16;

  exp_t        expq [2][$];
  logic [15:0] held_q [2];
  logic [15:0] held_r [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_restoring_divider #(.WIDTH(8), .SIGNED_EN(1'b1)) d8 (
    .clk(clk), .rst(rst), .start(st[0]), .signed_mode(sm[0]),
    .dividend(dd[0][7:0]), .divisor(dv[0][7:0]),
    .busy(bsy[0]), .done(dn[0]), .quotient(q8), .remainder(r8),
    .div_by_zero(dz[0]), .overflow(ov[0]));

  seq_restoring_divider #(.WIDTH(16), .SIGNED_EN(1'b1)) d16 (
    .clk(clk), .rst(rst), .start(st[1]), .signed_mode(sm[1]),
    .dividend(dd[1]), .divisor(dv[1]),
    .busy(bsy[1]), .done(dn[1]), .quotient(q16), .remainder(r16),
    .div_by_zero(dz[1]), .overflow(ov[1]));

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s dut%0d actual=0x%0h required=0x%0h (t=%0t)", nm, id, act, req, $time);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, remainder takes the dividend's sign.
  function automatic exp_t model(input int w, input bit sgn, input logic [15:0] a, input logic [15:0] b);
    exp_t   e;
    longint mask, half, sa, sb, qq, rr;
    mask = (64'sd1 <<< w) - 1;
    half = 64'sd1 <<< (w - 1);
    sa   = longint'(a) & mask;
    sb   = longint'(b) & mask;
    e.dz = 1'b0;
    e.ov = 1'b0;
    e.due = 0;
    if (sb == 0) begin
      qq   = mask;
      rr   = sa;
      e.dz = 1'b1;
    end else begin
      if (sgn) begin
        if (sa >= half) sa = sa - (mask + 1);
        if (sb >= half) sb = sb - (mask + 1);
        e.ov = (sa == -half) && (sb == -1);
      end
      qq = sa / sb;
      rr = sa % sb;
    end
    e.q = 16'(qq & mask);
    e.r = 16'(rr & mask);
    return e;
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] mask;
    mask = (w == 8) ? 16'h00FF : 16'hFFFF;
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return mask;
      2:       return 16'h1 << (w - 1);
      3:       return 16'h0001;
      default: return 16'($urandom) & mask;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that accepts the operation.
  task automatic issue(input int id, input bit sgn, input logic [15:0] a, input logic [15:0] b);
    exp_t        e;
    int          n;
    int          w;
    logic [15:0] mask;
    w    = (id == 0) ? 8 : 16;
    mask = (id == 0) ? 16'h00FF : 16'hFFFF;
    n    = 0;
    while (bsy[id] && n < 200) begin
      if (jm == 2 || (jm == 1 && $urandom_range(0, 3) == 0)) begin
        st[id] = 1'b1;
        sm[id] = 1'($urandom);
        dd[id] = 16'($urandom);
        dv[id] = 16'($urandom);
      end else begin
        st[id] = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) check("idle_timeout", id, 32'(bsy[id]), 32'd0);
    st[id] = 1'b1;
    sm[id] = sgn;
    dd[id] = a & mask;
    dv[id] = b & mask;
    e      = model(w, sgn, a, b);
    e.due  = cyc + 1 + (((b & mask) == 16'h0) ? 0 : w + 1);
    expq[id].push_back(e);
    @(posedge clk); #1;
    st[id] = 1'b0;
  endtask

  // lat counts edges from the edge before start was driven up to the one that raised done.
  task automatic run(input int id, input bit sgn, input logic [15:0] a, input logic [15:0] b,
                     output int lat, output int bcnt);
    issue(id, sgn, a, b);
    lat  = 1;
    bcnt = 0;
    while (!dn[id] && lat < 100) begin
      bcnt += int'(bsy[id]);
      @(posedge clk); #1;
      lat++;
    end
    if (!dn[id]) check("done_timeout", id, 32'(dn[id]), 32'd1);
  endtask

  task automatic sweep(input int id, input int n);
    int w;
    w = (id == 0) ? 8 : 16;
    for (int i = 0; i < n; i++) begin
      issue(id, 1'($urandom), pick(w), pick(w));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic chk(input int id, input logic [15:0] q, input logic [15:0] r,
                     input logic d, input logic b, input logic z, input logic o);
    exp_t e;
    if (rst) begin
      check("rst_outputs", id, {q, r}, 32'd0);
      check("rst_flags", id, {28'd0, d, b, z, o}, 32'd0);
      expq[id].delete();
      held_q[id] = '0;
      held_r[id] = '0;
    end else if (d) begin
      check("done_has_pending_op", id, 32'(expq[id].size() > 0), 32'd1);
      check("busy_low_at_done", id, 32'(b), 32'd0);
      if (expq[id].size() > 0) begin
        e = expq[id].pop_front();
        check("quotient", id, 32'(q), 32'(e.q));
        check("remainder", id, 32'(r), 32'(e.r));
        check("div_by_zero", id, 32'(z), 32'(e.dz));
        check("overflow", id, 32'(o), 32'(e.ov));
        check("done_cycle", id, 32'(cyc), 32'(e.due));
        held_q[id] = e.q;
        held_r[id] = e.r;
      end
    end else begin
      check("held_results", id, {q, r}, {held_q[id], held_r[id]});
    end
  endtask

  always @(negedge clk) begin
    chk(0, {8'h00, q8}, {8'h00, r8}, dn[0], bsy[0], dz[0], ov[0]);
    chk(1, q16, r16, dn[1], bsy[1], dz[1], ov[1]);
  end

  initial begin
    exp_t e;
    int   lat, bcnt, n;
    st = '0; sm = '0;
    dd[0] = '0; dd[1] = '0; dv[0] = '0; dv[1] = '0;
    held_q[0] = '0; held_q[1] = '0; held_r[0] = '0; held_r[1] = '0;

    // Model pinned against hand-computed results.
    e = model(8, 1'b0, 16'd200, 16'd7);
    check("model_200_7", 0, {e.q, e.r}, {16'd28, 16'd4});
    e = model(8, 1'b1, 16'hF9, 16'h02);
    check("model_m7_2", 0, {e.q, e.r}, {16'h00FD, 16'h00FF});
    e = model(8, 1'b1, 16'h80, 16'hFF);
    check("model_ovf", 0, {e.q, e.r, 15'd0, e.ov}, {16'h0080, 16'h0000, 16'd1});
    e = model(8, 1'b0, 16'd55, 16'd0);
    check("model_dz", 0, {e.q, e.r, 15'd0, e.dz}, {16'h00FF, 16'd55, 16'd1});
    e = model(16, 1'b0, 16'd40000, 16'd7);
    check("model16_u", 1, {e.q, e.r}, {16'd5714, 16'd2});
    e = model(16, 1'b1, 16'h8000, 16'd3);
    check("model16_s", 1, {e.q, e.r}, {16'hD556, 16'hFFFE});

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    run(0, 1'b0, 16'd200, 16'd7, lat, bcnt);
    check("u200_7_q", 0, {8'h00, q8, 8'h00, r8}, {16'd28, 16'd4});
    check("u200_7_latency", 0, lat, 10);
    check("u200_7_busy_cycles", 0, bcnt, 9);

    run(0, 1'b1, 16'hF9, 16'h02, lat, bcnt);
    check("s_m7_2", 0, {q8, r8, 6'd0, dz[0], ov[0]}, {8'hFD, 8'hFF, 8'h00});

    run(0, 1'b1, 16'h07, 16'hFE, lat, bcnt);
    check("s_7_m2", 0, {q8, r8}, {8'hFD, 8'h01});

    run(0, 1'b0, 16'd55, 16'd0, lat, bcnt);
    check("dz_55_0", 0, {q8, r8, 7'd0, dz[0]}, {8'hFF, 8'd55, 8'h01});
    check("dz_latency", 0, lat, 1);

    run(0, 1'b1, 16'h80, 16'hFF, lat, bcnt);
    check("ovf_m128_m1", 0, {q8, r8, 7'd0, ov[0]}, {8'h80, 8'h00, 8'h01});
    check("ovf_latency", 0, lat, 10);

    // Reset in the middle of CALC must abort at once and clear every output.
    issue(0, 1'b0, 16'd77, 16'd3);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_async_busy", 0, 32'(bsy[0]), 32'd0);
    check("rst_async_q", 0, {q8, r8}, 16'h0000);
    @(negedge clk); @(negedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run(0, 1'b0, 16'd100, 16'd10, lat, bcnt);
    check("after_rst_100_10", 0, {q8, r8}, {8'd10, 8'd0});
    check("after_rst_latency", 0, lat, 10);

    // start held high through busy, then a back-to-back start in the DONE cycle.
    jm = 2;
    issue(0, 1'b0, 16'd200, 16'd7);
    run(0, 1'b1, 16'hF9, 16'h02, lat, bcnt);
    check("b2b_result", 0, {q8, r8}, {8'hFD, 8'hFF});
    check("b2b_latency", 0, lat, 10);
    jm = 1;

    fork
      sweep(0, 2000);
      sweep(1, 2000);
    join

    n = 0;
    while ((expq[0].size() > 0 || expq[1].size() > 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 0, 32'(expq[0].size() + expq[1].size()), 32'd0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
